// File: rtl/tilelink_uart_tx.sv
// tilelink_uart_tx: TileLink-UL mapped 8N1 serial transmitter with a TX FIFO and programmable bit divisor.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
package tilelink_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
  } tilelink_a;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_size;
    logic [7:0]  d_source;
    logic        d_error;
    logic [31:0] d_data;
  } tilelink_d;
endpackage

module tilelink_uart_tx
  import tilelink_pkg::*;
#(
  parameter logic [31:0] addr_mask   = 32'hF000_0000,
  parameter logic [31:0] addr_tag    = 32'h4000_0000,
  parameter int          fifo_depth  = 8,
  parameter logic [15:0] default_div = 16'd16
) (
  input  logic      clock,
  input  logic      reset_in,
  input  tilelink_a tla,
  output tilelink_d tld,
  output logic      tx,
  output logic      irq_empty
);
  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = ptr_w + 1;
`ifdef UART_TX_PARITY_EN
  localparam logic parity_flag = 1'b1;
`else
  localparam logic parity_flag = 1'b0;
`endif

  // Handshake: a request is taken in any cycle a_valid is high (never back-pressured); each selected
  // request yields exactly one d_valid cycle next clock, and tld is all-zero otherwise for the OR-merge.

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  logic [7:0]       fifo_mem [fifo_depth];
  logic [ptr_w-1:0] wr_ptr, rd_ptr;
  logic [cnt_w-1:0] count;
  logic [15:0]      div_reg, div_latched, bit_timer, div_eff;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;
  state_t           state;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  logic        sel, is_get, is_put, fifo_full, fifo_empty, push_req, push, pop;
  logic [1:0]  reg_off;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign unused_bits = ^{tla.a_data[31:16], tla.a_mask[3:2]};

  always_comb begin
    sel        = tla.a_valid && ((tla.a_address & addr_mask) == addr_tag);
    reg_off    = tla.a_address[3:2];
    is_get     = (tla.a_opcode == 3'd4);
    is_put     = (tla.a_opcode == 3'd0) || (tla.a_opcode == 3'd1);
    fifo_full  = (count == cnt_w'(fifo_depth));
    fifo_empty = (count == '0);
    push_req   = sel && is_put && (reg_off == 2'd0) && tla.a_mask[0];
    push       = push_req && !fifo_full;
    pop        = (state == ST_IDLE) && !fifo_empty;
    div_eff    = (div_reg == 16'd0) ? 16'd1 : div_reg;
    rd_data    = '0;
    case (reg_off)
      2'd1:    rd_data = {16'd0, 8'(count), 4'd0, parity_flag, state != ST_IDLE, fifo_empty, fifo_full};
      2'd2:    rd_data = {16'd0, div_reg};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= tla.a_data[7:0];
  end

  always_ff @(posedge clock) begin
    if (!reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_in) begin
      div_reg <= default_div;
    end else if (sel && is_put && (reg_off == 2'd2)) begin
      if (tla.a_mask[0]) div_reg[7:0]  <= tla.a_data[7:0];
      if (tla.a_mask[1]) div_reg[15:8] <= tla.a_data[15:8];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_in || !sel) begin
      tld <= '0;
    end else begin
      tld.d_valid  <= 1'b1;
      tld.d_source <= tla.a_source;
      tld.d_size   <= tla.a_size;
      tld.d_opcode <= is_get ? 3'd1 : 3'd0;
      tld.d_data   <= is_get ? rd_data : 32'd0;
      tld.d_error  <= !(is_get || is_put) || (push_req && fifo_full);
    end
  end

  // Every non-idle state lasts div_latched clocks; the timer reloads on each bit boundary.
  always_ff @(posedge clock) begin
    if (!reset_in) begin
      state       <= ST_IDLE;
      tx          <= 1'b1;
      shift       <= '0;
      bit_idx     <= '0;
      bit_timer   <= '0;
      div_latched <= 16'd1;
      irq_empty   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit  <= 1'b0;
`endif
    end else begin
      irq_empty <= fifo_empty && (state == ST_IDLE);
      if (state == ST_IDLE) begin
        if (pop) begin
          shift       <= fifo_mem[rd_ptr];
          div_latched <= div_eff;
          bit_timer   <= div_eff - 16'd1;
          bit_idx     <= '0;
          tx          <= 1'b0;
          state       <= ST_START;
`ifdef UART_TX_PARITY_EN
          parity_bit  <= ^fifo_mem[rd_ptr];
`endif
        end
      end else if (bit_timer != 16'd0) begin
        bit_timer <= bit_timer - 16'd1;
      end else begin
        bit_timer <= div_latched - 16'd1;
        case (state)
          ST_START: begin
            tx    <= shift[0];
            shift <= shift >> 1;
            state <= ST_DATA;
          end
          ST_DATA: begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= ST_PARITY;
`else
              tx    <= 1'b1;
              state <= ST_STOP;
`endif
            end else begin
              tx      <= shift[0];
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end
`ifdef UART_TX_PARITY_EN
          ST_PARITY: begin
            tx    <= 1'b1;
            state <= ST_STOP;
          end
`endif
          ST_STOP: state <= ST_IDLE;
          default: begin
            tx    <= 1'b1;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tilelink_uart_tx.sv
// tb_tilelink_uart_tx: bus traffic against a transaction-level register/FIFO model, and a tx line monitor
// that checks every bit period of every frame against the expected byte queue.
module tb_tilelink_uart_tx;
  import tilelink_pkg::*;

  logic      clock = 1'b0;
  logic      reset_in;
  tilelink_a tla;
  tilelink_d tld;
  logic      tx;
  logic      irq_empty;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [7:0]  exp_q[$];
  int          start_q[$];
  int          cur_bit = -1;
  logic [15:0] model_div = 16'd16;
  bit          model_full = 1'b0;
  logic [31:0] model_status;

`ifdef UART_TX_PARITY_EN
  localparam int          n_bits   = 11;
  localparam logic [31:0] par_flag = 32'h8;
`else
  localparam int          n_bits   = 10;
  localparam logic [31:0] par_flag = 32'h0;
`endif
  localparam logic [31:0] st_idle = 32'h2 | par_flag;

  tilelink_uart_tx dut (
    .clock     (clock),
    .reset_in  (reset_in),
    .tla       (tla),
    .tld       (tld),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  // clock / cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: decides the response and updates DIV / queued bytes from the register map rules.
  task automatic model_access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] mask, output bit v, output logic [2:0] rop,
                              output logic [31:0] rdata, output bit err);
    v     = (addr[31:28] == 4'h4);
    rop   = 3'd0;
    rdata = 32'd0;
    err   = 1'b0;
    if (!v) return;
    case (op)
      3'd4: begin
        rop = 3'd1;
        case (addr[3:2])
          2'd1:    rdata = model_status;
          2'd2:    rdata = {16'd0, model_div};
          default: rdata = 32'd0;
        endcase
      end
      3'd0, 3'd1: begin
        case (addr[3:2])
          2'd0: if (mask[0]) begin
            if (model_full) err = 1'b1;
            else exp_q.push_back(data[7:0]);
          end
          2'd2: begin
            if (mask[0]) model_div[7:0]  = data[7:0];
            if (mask[1]) model_div[15:8] = data[15:8];
          end
          default: ;
        endcase
      end
      default: err = 1'b1;
    endcase
  endtask

  // Driver: issues one request at a negedge and checks the response one clock later.
  task automatic bus_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask);
    bit          v, err;
    logic [2:0]  rop, sz;
    logic [31:0] rdata;
    logic [7:0]  src;
    model_access(op, addr, data, mask, v, rop, rdata, err);
    src = 8'($urandom_range(0, 255));
    sz  = 3'($urandom_range(0, 2));
    tla.a_valid   = 1'b1;
    tla.a_opcode  = op;
    tla.a_size    = sz;
    tla.a_source  = src;
    tla.a_address = addr;
    tla.a_mask    = mask;
    tla.a_data    = data;
    @(negedge clock);
    tla.a_valid = 1'b0;
    check("d_valid", 32'(tld.d_valid), 32'(v));
    if (v) begin
      check("d_opcode", 32'(tld.d_opcode), 32'(rop));
      check("d_data",   tld.d_data, rdata);
      check("d_error",  32'(tld.d_error), 32'(err));
      check("d_source", 32'(tld.d_source), 32'(src));
      check("d_size",   32'(tld.d_size), 32'(sz));
    end else begin
      check("d_data_unsel", tld.d_data, 32'd0);
    end
  endtask

  task automatic do_reset();
    tla.a_valid = 1'b0;
    reset_in    = 1'b0;
    exp_q.delete();
    model_div  = 16'd16;
    model_full = 1'b0;
    @(negedge clock);
    check("rst_tx",      32'(tx), 32'd1);
    check("rst_irq",     32'(irq_empty), 32'd1);
    check("rst_d_valid", 32'(tld.d_valid), 32'd0);
    check("rst_d_data",  tld.d_data, 32'd0);
    reset_in = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || cur_bit >= 0) && n < 20000) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_drain"}, 32'(n < 20000), 32'd1);
    repeat (3) @(negedge clock);
    check({tag, "_irq"}, 32'(irq_empty), 32'd1);
    check({tag, "_tx_idle"}, 32'(tx), 32'd1);
  endtask

  task automatic wait_bit(input int k);
    int n = 0;
    while (cur_bit != k && n < 5000) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("reach_bit%0d", k), 32'(n < 5000), 32'd1);
  endtask

  // Scoreboard monitor: each frame must hold every bit for exactly DIV clocks.
  initial begin : tx_monitor
    logic [7:0]  b;
    logic [10:0] frame;
    int          d, idx, bit_no, n;
    logic        obs;
    bit          aborted;
    forever begin
      @(posedge clock);
      #1;
      if (reset_in === 1'b1 && tx === 1'b0) begin
        start_q.push_back(cycle);
        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) begin
          n = 0;
          while (tx === 1'b0 && reset_in === 1'b1 && n < 20000) begin
            @(posedge clock);
            #1;
            n++;
          end
        end else begin
          b = exp_q.pop_front();
          d = (model_div == 16'd0) ? 1 : int'(model_div);
`ifdef UART_TX_PARITY_EN
          frame = {1'b1, ^b, b, 1'b0};
`else
          frame = {1'b1, 1'b1, b, 1'b0};
`endif
          idx     = 0;
          aborted = 1'b0;
          obs     = 1'b0;
          while (idx < n_bits * d && !aborted) begin
            if (idx != 0) begin
              @(posedge clock);
              #1;
            end
            if (reset_in !== 1'b1) begin
              aborted = 1'b1;
            end else begin
              bit_no  = idx / d;
              cur_bit = bit_no;
              if (idx % d == 0) obs = frame[bit_no];
              if (tx !== frame[bit_no]) obs = tx;
              if (idx % d == d - 1)
                check($sformatf("tx_bit%0d_byte%02h", bit_no, b), 32'(obs), 32'(frame[bit_no]));
              idx++;
            end
          end
          cur_bit = -1;
        end
      end
    end
  end

  initial begin : stimulus
    logic [2:0]  op;
    logic [31:0] addr;
    int          nib;
    tla      = '0;
    reset_in = 1'b0;
    @(negedge clock);
    do_reset();
    model_status = st_idle;

    // reset register values
    bus_op(3'd4, 32'h4000_0004, 32'd0, 4'hF);
    bus_op(3'd4, 32'h4000_0008, 32'd0, 4'hF);
    @(negedge clock);
    check("d_valid_one_cycle", 32'(tld.d_valid), 32'd0);
    check("d_data_quiet", tld.d_data, 32'd0);

    // single frame 0xA5 at DIV=16
    bus_op(3'd0, 32'h4000_0000, 32'h0000_00A5, 4'h1);
    wait_drain("a5");

    // unselected, illegal opcode, dead offsets, masked-off byte lane
    bus_op(3'd4, 32'h5000_0004, 32'd0, 4'hF);
    bus_op(3'd0, 32'h5000_0000, 32'h0000_0011, 4'hF);
    bus_op(3'd2, 32'h4000_0000, 32'h0000_0022, 4'hF);
    bus_op(3'd0, 32'h4000_000C, 32'h0000_0033, 4'hF);
    bus_op(3'd4, 32'h4000_000C, 32'd0, 4'hF);
    bus_op(3'd0, 32'h4000_0000, 32'h0000_0044, 4'hE);
    bus_op(3'd0, 32'h4000_0004, 32'h0000_0055, 4'hF);
    repeat (40) @(negedge clock);
    bus_op(3'd4, 32'h4000_0004, 32'd0, 4'hF);

    // DIV written mid-frame only affects the next frame
    bus_op(3'd0, 32'h4000_0000, 32'h0000_003C, 4'h1);
    bus_op(3'd1, 32'h4000_0000, 32'h0000_00C3, 4'h1);
    wait_bit(3);
    bus_op(3'd0, 32'h4000_0008, 32'h0000_0004, 4'h3);
    wait_drain("div_mid");
    bus_op(3'd4, 32'h4000_0008, 32'd0, 4'hF);

    // DIV=0 runs at one clock per bit
    bus_op(3'd0, 32'h4000_0008, 32'h0000_0000, 4'h3);
    bus_op(3'd4, 32'h4000_0008, 32'd0, 4'hF);
    bus_op(3'd0, 32'h4000_0000, 32'h0000_005A, 4'h1);
    wait_drain("div0");

    // back-to-back frames: one idle clock between frames
    bus_op(3'd0, 32'h4000_0008, 32'h0000_0002, 4'h3);
    start_q.delete();
    bus_op(3'd0, 32'h4000_0000, 32'h0000_0081, 4'h1);
    bus_op(3'd0, 32'h4000_0000, 32'h0000_0018, 4'h1);
    bus_op(3'd0, 32'h4000_0000, 32'h0000_00FF, 4'h1);
    wait_drain("b2b");
    check("b2b_frames", 32'(start_q.size()), 32'd3);
    if (start_q.size() == 3) begin
      check("b2b_gap1", 32'(start_q[1] - start_q[0]), 32'(n_bits * 2 + 1));
      check("b2b_gap2", 32'(start_q[2] - start_q[1]), 32'(n_bits * 2 + 1));
    end

    // randomized rounds
    for (int r = 0; r < 16; r++) begin
      int dv = $urandom_range(0, 5);
      int nb = $urandom_range(1, 5);
      bus_op(3'd0, 32'h4000_0008, 32'(dv) | ($urandom & 32'hFFFF_0000), 4'h3);
      bus_op(3'd4, 32'h4000_0008, 32'd0, 4'hF);
      for (int i = 0; i < nb; i++) begin
        int kind = $urandom_range(0, 5);
        case (kind)
          0, 1, 2: bus_op(3'($urandom_range(0, 1)), 32'h4000_0000 | ($urandom & 32'h0FFF_FFF0),
                          $urandom, 4'($urandom_range(0, 15)));
          3: begin
            op = 3'($urandom_range(2, 7));
            if (op == 3'd4) op = 3'd5;
            bus_op(op, 32'h4000_0000 | 32'($urandom_range(0, 3) * 4), $urandom, 4'hF);
          end
          4: bus_op(3'd4, ($urandom_range(0, 1) != 0) ? 32'h4000_000C : 32'h4000_0000, 32'd0, 4'hF);
          default: begin
            nib = $urandom_range(0, 14);
            if (nib >= 4) nib++;
            addr = $urandom;
            addr[31:28] = 4'(nib);
            bus_op(3'($urandom_range(0, 7)), addr, $urandom, 4'hF);
          end
        endcase
        repeat ($urandom_range(0, 3)) @(negedge clock);
      end
      wait_drain("rnd");
      bus_op(3'd4, 32'h4000_0004, 32'd0, 4'hF);
    end

    // fill the FIFO at DIV=1000: ninth queued write overflows
    bus_op(3'd0, 32'h4000_0008, 32'd1000, 4'h3);
    for (int i = 0; i < 9; i++) bus_op(3'd0, 32'h4000_0000, 32'(8'h60 + i), 4'h1);
    model_full = 1'b1;
    bus_op(3'd0, 32'h4000_0000, 32'h0000_00EE, 4'h1);
    model_full   = 1'b0;
    model_status = 32'h0000_0805 | par_flag;
    bus_op(3'd4, 32'h4000_0004, 32'd0, 4'hF);
    do_reset();
    model_status = st_idle;
    bus_op(3'd4, 32'h4000_0004, 32'd0, 4'hF);
    bus_op(3'd4, 32'h4000_0008, 32'd0, 4'hF);

    // reset during data bit 3 discards the frame and the queued byte
    bus_op(3'd0, 32'h4000_0000, 32'h0000_003C, 4'h1);
    bus_op(3'd0, 32'h4000_0000, 32'h0000_0081, 4'h1);
    wait_bit(4);
    do_reset();
    repeat (60) @(negedge clock);
    check("post_rst_tx", 32'(tx), 32'd1);
    check("post_rst_irq", 32'(irq_empty), 32'd1);
    bus_op(3'd4, 32'h4000_0004, 32'd0, 4'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tilelink_uart_tx.md
Name: tilelink_uart_tx

Overview:
- Memory-mapped TileLink-UL serial transmitter at data-bus tag 0x4xxxxxxx, the console address range.
- Consumes the core's bus_tla stream alongside data_ram and debug_reg2; its tld joins the top-level bus_to_core OR-merge.
- Buffers written bytes in a FIFO and serialises them 8N1, LSB first, on a tx pin with a programmable divisor.

Parameters:
addr_mask, 32'hF0000000, address bits compared for select
addr_tag, 32'h40000000, select value after masking
fifo_depth, 8, TX FIFO entries; power of 2, 2..64
default_div, 16, reset value of DIV register (clocks per bit)

Ports:
clock  input  1  global clock, all state on rising edge
reset_in  input  1  synchronous, active-low reset; 0 = reset asserted
tla  input  tilelink_a  request channel from core (bus_tla)
tld  output  tilelink_d  response channel to top-level merge
tx  output  1  serial line, idle high
irq_empty  output  1  high when FIFO empty and transmitter idle

Behaviour:
- Reset (reset_in==0 at clock edge):
  - FIFO emptied; FSM to IDLE; tx=1; DIV=default_div; tld.d_valid=0; tld fields=0; irq_empty=1.
  - Applies mid-frame: tx is high the cycle after reset, and the partial byte is discarded.
- Select: tla.a_valid && ((tla.a_address & addr_mask) == addr_tag). Register offset = a_address[3:2].
- tla.a_ready is not driven; the block always accepts.
- Response timing:
  - One cycle after a selected request: d_valid=1 for exactly one cycle; d_source and d_size echo the request.
  - Unselected cycles: d_valid=0 and d_data=0, required for the OR-merge.
- Opcodes:
  - Get(4) -> AccessAckData(1).
  - PutFullData(0) or PutPartialData(1) -> AccessAck(0).
  - Any other opcode -> AccessAck with d_error=1, no side effect.
- Registers:
  - 0x0 TXDATA (W): if a_mask[0], push a_data[7:0]. Push while full drops the byte and sets d_error=1. Read returns 0.
  - 0x4 STATUS (R): bit0 full, bit1 empty, bit2 busy (FSM!=IDLE), bits[15:8] FIFO count. Writes ignored.
  - 0x8 DIV (RW): bits[15:0], byte lanes by a_mask[1:0]. DIV=0 behaves as 1. Sampled at frame start; a mid-frame write affects the next frame only.
  - 0xC: reads 0; writes ignored; no error.
- FIFO:
  - Push and pop in the same cycle are both legal when non-empty; count unchanged.
  - Pointers wrap modulo fifo_depth.
  - Count width is clog2(fifo_depth)+1 so full is distinguishable from empty.
- TX FSM (bit timer counts div_latched-1 down to 0; each state lasts div_latched clocks):
  - IDLE: tx=1. If FIFO non-empty: pop into shift register, latch DIV, go to START. Pop and START begin the same cycle.
  - START: tx=0.
  - DATA: tx=shift[0]; shift right each bit; 8 bits, then STOP.
  - STOP: tx=1 for one bit time. Then IDLE, and a queued byte starts on the following cycle (back-to-back frame is 10 bit times + 1 clock).
- irq_empty is registered: (count==0 && state==IDLE).

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives even parity (XOR of the 8 data bits) for one bit time; frame = 11 bit times.
  - STATUS bit3 reads 1.
- When undefined: no PARITY state, frame = 10 bit times, STATUS bit3 reads 0.

Test Plan:
- Reset, then Get 0x40000004 -> d_valid one cycle later, AccessAckData, d_data=0x00000002 (empty). Get 0x40000008 -> 0x10.
- PutFullData 0x40000000 data 0xA5, DIV=16 -> tx low 16 clocks, then bits 1,0,1,0,0,1,0,1 at 16 clocks each, then high 16 clocks; irq_empty returns to 1.
- Write 9 bytes back-to-back with DIV=1000 -> first pops immediately; bytes 2..9 fill the FIFO. Next write -> d_error=1, byte dropped. STATUS read -> full=1, count=8.
- Write DIV=4 mid-frame at DIV=16 -> current frame stays 16 clocks/bit; next frame 4 clocks/bit. DIV=0 -> 1 clock/bit.
- Drive reset_in=0 during DATA bit 3 -> tx=1 the following cycle, STATUS=0x2 after release, no residual bits.
- Get 0x50000004 (unselected) -> d_valid stays 0, d_data=0. Opcode 2 to 0x40000000 -> AccessAck, d_error=1, FIFO unchanged.
